// File: rtl/dbg_status_mux.sv
// Debug presenter: latches NUM_CH debug words and shows the selected one (live/sticky/stretch/hold) on LEDs and 4-digit hex.
// Latency dbg_in/ch_sel->led 2 cycles, mode->led 1, led->seg/an/dp 1; no backpressure, inputs sampled every cycle.
module dbg_status_mux #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 16,
    parameter int STRETCH_CYCLES = 1000000,
    parameter int REFRESH_DIV    = 100000
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [NUM_CH*CH_W-1:0]                       dbg_in,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic [1:0]                                   mode,
    input  logic                                         clear,
    output logic [CH_W-1:0]                              led,
    output logic [6:0]                                   seg,
    output logic [3:0]                                   an,
    output logic                                         dp,
    output logic                                         sel_err
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);
    localparam int REF_W = $clog2(REFRESH_DIV);

    localparam logic [1:0] MODE_LIVE    = 2'b00;
    localparam logic [1:0] MODE_STICKY  = 2'b01;
    localparam logic [1:0] MODE_STRETCH = 2'b10;
    localparam logic [1:0] MODE_HOLD    = 2'b11;

    logic [CH_W-1:0]  dbg_q    [NUM_CH];
    logic [CH_W-1:0]  sticky_q [NUM_CH];
    logic [CH_W-1:0]  sticky_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q    [CH_W];
    logic [CNT_W-1:0] cnt_d    [CH_W];
    logic [SEL_W-1:0] sel_q;
    logic [CH_W-1:0]  led_q, led_d, hold_q, hold_d;
    logic [1:0]       mode_q;
    logic             sel_err_q;
    logic [REF_W-1:0] ref_q, ref_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             dp_q, dp_d;

    logic [CH_W-1:0]  sel_word, sel_sticky, stretch_vec;
    logic             sel_bad, stretch_kill, ref_wrap, hold_entry;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Out-of-range selects fall through to an all-zero word in every mode.
    always_comb begin
        sel_word   = '0;
        sel_sticky = '0;
        sel_bad    = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(sel_q) == k) begin
                sel_word   = dbg_q[k];
                sel_sticky = sticky_q[k];
                sel_bad    = 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sticky_d[k] = clear ? '0 : (sticky_q[k] | dbg_q[k]);
        end
    end

    // A select change or clear kills the stretch both in the counters and on the next led value.
    assign stretch_kill = clear | (ch_sel != sel_q);

    always_comb begin
        stretch_vec = '0;
        for (int b = 0; b < CH_W; b++) begin
            cnt_d[b] = cnt_q[b];
            if (stretch_kill) begin
                cnt_d[b] = '0;
            end else if (sel_word[b]) begin
                cnt_d[b] = CNT_W'(STRETCH_CYCLES);
            end else if (cnt_q[b] != '0) begin
                cnt_d[b] = cnt_q[b] - CNT_W'(1);
            end
            stretch_vec[b] = (cnt_q[b] != '0) & ~stretch_kill;
        end
    end

    assign hold_entry = (mode == MODE_HOLD) && (mode_q != MODE_HOLD);

    always_comb begin
        hold_d = hold_entry ? led_q : hold_q;
        case (mode)
            MODE_LIVE:    led_d = sel_word;
            MODE_STICKY:  led_d = sel_sticky;
            MODE_STRETCH: led_d = sel_word | stretch_vec;
            default:      led_d = hold_entry ? led_q : hold_q;
        endcase
    end

    always_comb begin
        ref_wrap = (ref_q == REF_W'(REFRESH_DIV - 1));
        ref_d    = ref_wrap ? '0 : ref_q + REF_W'(1);
        idx_d    = ref_wrap ? idx_q + 2'd1 : idx_q;
        an_d     = ~(4'b0001 << idx_q);
        seg_d    = hex7(led_q[4*idx_q +: 4]);
        if (mode == MODE_HOLD) begin
            dp_d = 1'b0;
        end else begin
            dp_d = ~(sel_err_q && (idx_q == 2'd3));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                dbg_q[k]    <= '0;
                sticky_q[k] <= '0;
            end
            for (int b = 0; b < CH_W; b++) begin
                cnt_q[b] <= '0;
            end
            sel_q     <= '0;
            led_q     <= '0;
            hold_q    <= '0;
            mode_q    <= MODE_LIVE;
            sel_err_q <= 1'b0;
            ref_q     <= '0;
            idx_q     <= '0;
            seg_q     <= 7'h7F;
            an_q      <= 4'hF;
            dp_q      <= 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                dbg_q[k]    <= dbg_in[k*CH_W +: CH_W];
                sticky_q[k] <= sticky_d[k];
            end
            for (int b = 0; b < CH_W; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            sel_q     <= ch_sel;
            led_q     <= led_d;
            hold_q    <= hold_d;
            mode_q    <= mode;
            sel_err_q <= sel_bad;
            ref_q     <= ref_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign led     = led_q;
    assign seg     = seg_q;
    assign an      = an_q;
    assign dp      = dp_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_dbg_status_mux.sv
// Directed bench for dbg_status_mux: 4-channel build for live/sticky/stretch/hold/reset, 3-channel build for invalid select.
module tb_dbg_status_mux;
    localparam int RD = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] dbg_in;
    logic [1:0]  ch_sel, mode;
    logic        clear;
    logic [15:0] led;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp, sel_err;

    logic [47:0] dbg1;
    logic [1:0]  sel1, mode1;
    logic        clear1;
    logic [15:0] led1;
    logic [6:0]  seg1;
    logic [3:0]  an1;
    logic        dp1, sel_err1;

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    dbg_status_mux #(.NUM_CH(4), .CH_W(16), .STRETCH_CYCLES(5), .REFRESH_DIV(RD)) u_dut (
        .clk(clk), .rst_n(rst_n), .dbg_in(dbg_in), .ch_sel(ch_sel), .mode(mode), .clear(clear),
        .led(led), .seg(seg), .an(an), .dp(dp), .sel_err(sel_err)
    );

    dbg_status_mux #(.NUM_CH(3), .CH_W(16), .STRETCH_CYCLES(5), .REFRESH_DIV(RD)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .dbg_in(dbg1), .ch_sel(sel1), .mode(mode1), .clear(clear1),
        .led(led1), .seg(seg1), .an(an1), .dp(dp1), .sel_err(sel_err1)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            edge_cnt++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; dbg_in = '0; ch_sel = '0; mode = 2'b00; clear = 1'b0;
        dbg1 = '0; sel1 = '0; mode1 = 2'b00; clear1 = 1'b0;
        #12;
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL reset_led: got %h want 0000", led); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %b want 1111111", seg); end
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %b want 1111", an); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", dp); end
        checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b want 0", sel_err); end
    endtask

    task automatic test_live_scan;
        dbg_in[2*16 +: 16] = 16'hA5C3;
        ch_sel = 2'd2;
        rst_n = 1'b1;
        edge_cnt = 0;
        step(1);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL scan_first_an: got %b want 1110", an); end
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL live_latency1: got %h want 0000", led); end
        step(1);
        checks++; if (led !== 16'hA5C3) begin errors++; $display("FAIL live_latency2: got %h want a5c3", led); end
        step(1);
        checks++; if (an !== 4'b1110 || seg !== 7'b0110000) begin errors++; $display("FAIL scan_d0: got an=%b seg=%b want 1110/0110000", an, seg); end
        step(2);
        checks++; if (an !== 4'b1101 || seg !== 7'b1000110) begin errors++; $display("FAIL scan_d1: got an=%b seg=%b want 1101/1000110", an, seg); end
        step(4);
        checks++; if (an !== 4'b1011 || seg !== 7'b0010010) begin errors++; $display("FAIL scan_d2: got an=%b seg=%b want 1011/0010010", an, seg); end
        step(4);
        checks++; if (an !== 4'b0111 || seg !== 7'b0001000 || dp !== 1'b1) begin errors++; $display("FAIL scan_d3: got an=%b seg=%b dp=%b want 0111/0001000/1", an, seg, dp); end
        step(4);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL scan_wrap: got %b want 1110", an); end
    endtask

    task automatic test_sticky;
        dbg_in = '0; mode = 2'b01; ch_sel = 2'd1;
        step(3);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL sticky_init: got %h want 0000", led); end
        dbg_in[16 +: 16] = 16'h0001; step(1);
        dbg_in[16 +: 16] = 16'h0100; step(1);
        dbg_in[16 +: 16] = 16'h0000; step(3);
        checks++; if (led !== 16'h0101) begin errors++; $display("FAIL sticky_accum: got %h want 0101", led); end
        step(4);
        checks++; if (led !== 16'h0101) begin errors++; $display("FAIL sticky_hold: got %h want 0101", led); end
        clear = 1'b1; step(1);
        clear = 1'b0;
        checks++; if (led !== 16'h0101) begin errors++; $display("FAIL sticky_clear_early: got %h want 0101", led); end
        step(1);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL sticky_clear: got %h want 0000", led); end
        dbg_in[16 +: 16] = 16'h0002; step(1);
        clear = 1'b1; dbg_in[16 +: 16] = 16'h0000; step(1);
        clear = 1'b0; step(3);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL sticky_clear_wins: got %h want 0000", led); end
    endtask

    task automatic test_stretch;
        dbg_in = '0; mode = 2'b10; ch_sel = 2'd0;
        step(3);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL stretch_init: got %h want 0000", led); end
        dbg_in[3] = 1'b1; step(1);
        dbg_in[3] = 1'b0;
        checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL stretch_pre: got %b want 0", led[3]); end
        for (int i = 1; i <= 7; i++) begin
            step(1);
            checks++;
            if (led[3] !== 1'(i <= 6)) begin
                errors++; $display("FAIL stretch_len[%0d]: got %b want %b", i, led[3], 1'(i <= 6));
            end
        end
        dbg_in[3] = 1'b1; step(1);
        dbg_in[3] = 1'b0; step(3);
        dbg_in[3] = 1'b1; step(1);
        dbg_in[3] = 1'b0; step(6);
        checks++; if (led[3] !== 1'b1) begin errors++; $display("FAIL stretch_retrig_on: got %b want 1", led[3]); end
        step(1);
        checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL stretch_retrig_off: got %b want 0", led[3]); end
        dbg_in[3] = 1'b1; step(1);
        dbg_in[3] = 1'b0; step(2);
        checks++; if (led[3] !== 1'b1) begin errors++; $display("FAIL stretch_mid: got %b want 1", led[3]); end
        ch_sel = 2'd1; step(1);
        checks++; if (led[3] !== 1'b0) begin errors++; $display("FAIL stretch_selchg: got %b want 0", led[3]); end
    endtask

    task automatic test_hold;
        dbg_in = '0; dbg_in[15:0] = 16'h1234; mode = 2'b00; ch_sel = 2'd0;
        step(3);
        checks++; if (led !== 16'h1234) begin errors++; $display("FAIL hold_live: got %h want 1234", led); end
        mode = 2'b11; step(1);
        dbg_in[15:0] = 16'hFFFF; dbg_in[48 +: 16] = 16'h3C3C; ch_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            step(4);
            checks++;
            if (led !== 16'h1234 || dp !== 1'b0) begin
                errors++; $display("FAIL hold_frozen[%0d]: got led=%h dp=%b want 1234/0", i, led, dp);
            end
        end
        mode = 2'b00; step(1);
        checks++; if (led !== 16'h3C3C || dp !== 1'b1) begin errors++; $display("FAIL hold_exit: got led=%h dp=%b want 3c3c/1", led, dp); end
    endtask

    task automatic test_invalid_sel;
        int        eidx;
        logic [3:0] exp_an;
        logic       exp_dp;
        dbg1 = 48'hFFFF_FFFF_FFFF; sel1 = 2'd3;
        step(1);
        checks++; if (sel_err1 !== 1'b0) begin errors++; $display("FAIL inv_err_latency: got %b want 0", sel_err1); end
        step(1);
        checks++; if (sel_err1 !== 1'b1 || led1 !== 16'h0000) begin errors++; $display("FAIL inv_sel: got err=%b led=%h want 1/0000", sel_err1, led1); end
        for (int i = 0; i < 16; i++) begin
            step(1);
            eidx   = ((edge_cnt - 1) / RD) % 4;
            exp_an = ~(4'b0001 << eidx);
            exp_dp = (eidx == 3) ? 1'b0 : 1'b1;
            checks++;
            if (an1 !== exp_an || dp1 !== exp_dp) begin
                errors++; $display("FAIL inv_dp[%0d]: got an=%b dp=%b want %b/%b", i, an1, dp1, exp_an, exp_dp);
            end
        end
    endtask

    task automatic test_reset_mid;
        dbg_in = '0; mode = 2'b10; ch_sel = 2'd0;
        step(2);
        dbg_in[3] = 1'b1; step(1);
        dbg_in[3] = 1'b0; step(2);
        checks++; if (led[3] !== 1'b1) begin errors++; $display("FAIL rst_pre_stretch: got %b want 1", led[3]); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (led !== 16'h0000 || seg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || sel_err !== 1'b0) begin
            errors++; $display("FAIL rst_async: got led=%h seg=%b an=%b dp=%b err=%b", led, seg, an, dp, sel_err);
        end
        #10;
        rst_n = 1'b1; mode = 2'b01; ch_sel = 2'd0;
        edge_cnt = 0;
        step(1);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL rst_scan_restart: got %b want 1110", an); end
        step(1);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL rst_sticky_cleared: got %h want 0000", led); end
    endtask

    initial begin
        test_reset();
        test_live_scan();
        test_sticky();
        test_stretch();
        test_hold();
        test_invalid_sel();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
